// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared state encoding, code constants and symbol type for the frame sequencer
package viterbi_pkg;
  localparam int K = 3;
  localparam int TAIL_LEN = 2;
  typedef logic [1:0] sym_pair_t;
  typedef enum logic [2:0] {IDLE, ACC, TB_START, TB, TB_FLUSH, DRAIN} state_t;
endpackage

// File: rtl/viterbi_frame_ctrl_if.sv
// viterbi_frame_ctrl_if: symbol input stream and decoded-bit output stream
interface viterbi_frame_ctrl_if;
  logic in_valid;
  logic in_ready;
  viterbi_pkg::sym_pair_t rx_pair;
  logic out_valid;
  logic out_ready;
  logic out_bit;
  logic frame_done;
  modport master(output in_valid, rx_pair, out_ready, input in_ready, out_valid, out_bit, frame_done);
  modport slave(input in_valid, rx_pair, out_ready, output in_ready, out_valid, out_bit, frame_done);
endinterface

// File: rtl/viterbi_out_buf.sv
// viterbi_out_buf: captures traceback bits by address and drains them in ascending order
module viterbi_out_buf #(
  parameter int FRAME_LEN = 256,
  parameter int AW = $clog2(FRAME_LEN),
  parameter int N_OUT = FRAME_LEN
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  input  logic          tb_bit,
  input  logic          drain,
  input  logic          out_ready,
  output logic          out_valid,
  output logic          out_bit,
  output logic          frame_done,
  output logic          done
);
  logic [FRAME_LEN-1:0] mem_q, mem_d;
  logic [AW-1:0] cap_idx_q, cap_idx_d, idx_q, idx_d;
  logic cap_q, cap_d, out_valid_q, out_valid_d, out_bit_q, out_bit_d, frame_done_q, frame_done_d;
  logic xfer;
  assign xfer = out_valid_q & out_ready;
  assign done = xfer && idx_q == AW'(N_OUT - 1);
  assign out_valid = out_valid_q;
  assign out_bit = out_bit_q;
  assign frame_done = frame_done_q;
  // write the returning bit, then pick the next bit to present (mem_d forwards a same-cycle write)
  always_comb begin
    mem_d = mem_q;
    if (cap_q) mem_d[cap_idx_q] = tb_bit;
    cap_d = rd_en;
    cap_idx_d = rd_addr;
    idx_d = xfer ? (done ? '0 : idx_q + 1'b1) : idx_q;
    out_valid_d = drain & ~done;
    out_bit_d = out_valid_d ? mem_d[idx_d] : 1'b0;
    frame_done_d = done;
  end
  // buffer, drain pointer and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
      cap_q <= 1'b0;
      cap_idx_q <= '0;
      idx_q <= '0;
      out_valid_q <= 1'b0;
      out_bit_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      cap_q <= cap_d;
      cap_idx_q <= cap_idx_d;
      idx_q <= idx_d;
      out_valid_q <= out_valid_d;
      out_bit_q <= out_bit_d;
      frame_done_q <= frame_done_d;
    end
  end
endmodule

// File: rtl/viterbi_frame_ctrl.sv
// viterbi_frame_ctrl: Viterbi frame sequencer (accumulate, traceback, drain); VITERBI_TAIL_FLUSH_EN enables zero-tail frames
module viterbi_frame_ctrl
  import viterbi_pkg::*;
#(
  parameter int FRAME_LEN = 256,
  parameter int AW = $clog2(FRAME_LEN)
) (
  input  logic                 clk,
  input  logic                 rst,
  viterbi_frame_ctrl_if.slave  bus,
  output sym_pair_t            bmc_rx_pair,
  output logic                 acs_en,
  output logic                 acs_init,
  output logic                 surv_wr_en,
  output logic [AW-1:0]        surv_wr_addr,
  output logic                 tb_start,
  output logic                 tb_en,
  output logic [AW-1:0]        tb_addr,
`ifdef VITERBI_TAIL_FLUSH_EN
  output logic                 tb_force_zero,
`endif
  input  logic                 tb_bit
);
`ifdef VITERBI_TAIL_FLUSH_EN
  localparam int N_OUT = FRAME_LEN - TAIL_LEN;
  logic tb_force_zero_q;
  assign tb_force_zero = tb_force_zero_q;
`else
  localparam int N_OUT = FRAME_LEN;
`endif
  localparam logic [AW-1:0] LAST = AW'(FRAME_LEN - 1);
  state_t state_q, state_d;
  logic [AW-1:0] sym_cnt_q, sym_cnt_d, tb_cnt_q, tb_cnt_d, surv_wr_addr_q, surv_wr_addr_d, tb_addr_q, tb_addr_d;
  sym_pair_t bmc_q, bmc_d;
  logic in_ready_q, in_ready_d, acs_en_q, acs_en_d, acs_init_q, acs_init_d;
  logic tb_start_q, tb_start_d, tb_en_q, tb_en_d;
  logic xfer_in, drain_done;
  assign xfer_in = bus.in_valid & in_ready_q;
  assign bus.in_ready = in_ready_q;
  assign bmc_rx_pair = bmc_q;
  assign acs_en = acs_en_q;
  assign surv_wr_en = acs_en_q;
  assign acs_init = acs_init_q;
  assign surv_wr_addr = surv_wr_addr_q;
  assign tb_start = tb_start_q;
  assign tb_en = tb_en_q;
  assign tb_addr = tb_addr_q;
  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, ACC: if (xfer_in) state_d = (sym_cnt_q == LAST) ? TB_START : ACC;
      TB_START:  state_d = TB;
      TB:        if (tb_cnt_q == LAST) state_d = TB_FLUSH;
      TB_FLUSH:  state_d = DRAIN;
      DRAIN:     if (drain_done) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end
  // counters and registered outputs; traceback outputs trail the state by one cycle so tb_start follows the last ACS update
  always_comb begin
    sym_cnt_d = xfer_in ? sym_cnt_q + 1'b1 : sym_cnt_q;
    tb_cnt_d = (state_q == TB) ? tb_cnt_q + 1'b1 : tb_cnt_q;
    in_ready_d = state_d == IDLE || state_d == ACC;
    acs_en_d = xfer_in;
    acs_init_d = xfer_in && sym_cnt_q == '0;
    surv_wr_addr_d = xfer_in ? sym_cnt_q : surv_wr_addr_q;
    bmc_d = xfer_in ? bus.rx_pair : bmc_q;
    tb_start_d = state_q == TB_START;
    tb_en_d = state_q == TB;
    tb_addr_d = tb_en_d ? ~tb_cnt_q : tb_addr_q;
  end
  // counter and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sym_cnt_q <= '0;
      tb_cnt_q <= '0;
      in_ready_q <= 1'b1;
      acs_en_q <= 1'b0;
      acs_init_q <= 1'b0;
      surv_wr_addr_q <= '0;
      bmc_q <= '0;
      tb_start_q <= 1'b0;
      tb_en_q <= 1'b0;
      tb_addr_q <= '0;
    end else begin
      sym_cnt_q <= sym_cnt_d;
      tb_cnt_q <= tb_cnt_d;
      in_ready_q <= in_ready_d;
      acs_en_q <= acs_en_d;
      acs_init_q <= acs_init_d;
      surv_wr_addr_q <= surv_wr_addr_d;
      bmc_q <= bmc_d;
      tb_start_q <= tb_start_d;
      tb_en_q <= tb_en_d;
      tb_addr_q <= tb_addr_d;
    end
  end
`ifdef VITERBI_TAIL_FLUSH_EN
  // tail-flushed frames always trace back from state 00
  always_ff @(posedge clk) begin
    if (rst) tb_force_zero_q <= 1'b0;
    else tb_force_zero_q <= tb_start_d;
  end
`endif
  viterbi_out_buf #(.FRAME_LEN(FRAME_LEN), .AW(AW), .N_OUT(N_OUT)) u_out_buf (
    .clk(clk),
    .rst(rst),
    .rd_en(tb_en_q),
    .rd_addr(tb_addr_q),
    .tb_bit(tb_bit),
    .drain(state_q == DRAIN),
    .out_ready(bus.out_ready),
    .out_valid(bus.out_valid),
    .out_bit(bus.out_bit),
    .frame_done(bus.frame_done),
    .done(drain_done)
  );
endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// tb_viterbi_frame_ctrl: randomized frame-level checks of viterbi_frame_ctrl against a queue-based reference
module tb_viterbi_frame_ctrl;
  import viterbi_pkg::*;
  localparam int N = 8;
  localparam int AW = 3;
`ifdef VITERBI_TAIL_FLUSH_EN
  localparam int N_OUT = N - 2;
  logic tb_force_zero;
`else
  localparam int N_OUT = N;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  sym_pair_t bmc_rx_pair;
  logic acs_en, acs_init, surv_wr_en, tb_start, tb_en, tb_bit;
  logic [AW-1:0] surv_wr_addr, tb_addr;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  viterbi_frame_ctrl_if bus();
  viterbi_frame_ctrl #(.FRAME_LEN(N)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .bmc_rx_pair(bmc_rx_pair),
    .acs_en(acs_en),
    .acs_init(acs_init),
    .surv_wr_en(surv_wr_en),
    .surv_wr_addr(surv_wr_addr),
    .tb_start(tb_start),
    .tb_en(tb_en),
    .tb_addr(tb_addr),
`ifdef VITERBI_TAIL_FLUSH_EN
    .tb_force_zero(tb_force_zero),
`endif
    .tb_bit(tb_bit)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_outputs();
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_acs_en", acs_en, 0);
    check("rst_acs_init", acs_init, 0);
    check("rst_surv_wr_en", surv_wr_en, 0);
    check("rst_surv_wr_addr", surv_wr_addr, 0);
    check("rst_bmc", bmc_rx_pair, 0);
    check("rst_tb_start", tb_start, 0);
    check("rst_tb_en", tb_en, 0);
    check("rst_tb_addr", tb_addr, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_bit", bus.out_bit, 0);
    check("rst_frame_done", bus.frame_done, 0);
  endtask

  // mode: 0 random valid, 1 back-to-back, 2 alternating; stall holds out_ready low 5 cycles after bit 3
  task automatic run_frame(input int mode, input bit stall, input bit directed, input bit rst_mid);
    logic [N-1:0] bits;
    bit exp_q[$];
    int sent, prev_addr, got, stall_left, cyc;
    bit prev_x, prev_valid, prev_ready, last_pop, done;
    sym_pair_t prev_rx;
    bits = directed ? N'(8'b1011_0010) : N'($urandom);
    sent = 0; prev_x = 0; prev_addr = 0; prev_rx = '0; cyc = 0;
    while (sent < N && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      check("acc_in_ready", bus.in_ready, 1);
      check("acs_en", acs_en, prev_x);
      if (prev_x) begin
        check("surv_wr_en", surv_wr_en, 1);
        check("surv_wr_addr", surv_wr_addr, prev_addr);
        check("bmc_rx_pair", bmc_rx_pair, prev_rx);
        check("acs_init", acs_init, prev_addr == 0);
      end
      bus.in_valid = mode == 1 ? 1'b1 : mode == 2 ? cyc[0] : ($urandom_range(99) < 70);
      bus.rx_pair = sym_pair_t'($urandom);
      prev_x = bus.in_valid;
      if (prev_x) begin
        prev_addr = sent;
        prev_rx = bus.rx_pair;
        sent++;
      end
    end
    if (sent < N) check("accept_timeout", 0, 1);
    @(negedge clk);
    check("last_acs_en", acs_en, 1);
    check("last_addr", surv_wr_addr, N - 1);
    check("last_bmc", bmc_rx_pair, prev_rx);
    check("full_in_ready", bus.in_ready, 0);
    check("early_tb_start", tb_start, 0);
    bus.in_valid = 1'b1;
    @(negedge clk);
    check("tb_start", tb_start, 1);
    check("no_accept_acs_en", acs_en, 0);
`ifdef VITERBI_TAIL_FLUSH_EN
    check("tb_force_zero", tb_force_zero, 1);
`endif
    for (int k = 0; k <= N; k++) begin
      @(negedge clk);
      if (k > 0) tb_bit = bits[N - k];
      check("tb_start_pulse", tb_start, 0);
      check("tb_en", tb_en, k < N);
      if (k < N) begin
        check("tb_addr", tb_addr, N - 1 - k);
        if (rst_mid && N - 1 - k == 4) begin
          rst = 1'b1;
          bus.in_valid = 1'b0;
          @(negedge clk);
          check_idle_outputs();
          rst = 1'b0;
          return;
        end
      end
    end
    for (int i = 0; i < N_OUT; i++) exp_q.push_back(bits[i]);
    got = 0; stall_left = stall ? 5 : 0; last_pop = 0; done = 0; prev_valid = 0; prev_ready = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      check("frame_done", bus.frame_done, last_pop);
      if (last_pop) begin
        done = 1;
        check("done_in_ready", bus.in_ready, 1);
        check("done_out_valid", bus.out_valid, 0);
        bus.in_valid = 1'b0;
      end else begin
        check("drain_in_ready", bus.in_ready, 0);
        check("drain_acs_en", acs_en, 0);
        if (prev_valid && !prev_ready) check("valid_hold", bus.out_valid, 1);
        if (bus.out_valid) check("out_bit", bus.out_bit, exp_q[got]);
        if (got == 3 && stall_left > 0 && bus.out_valid) begin
          bus.out_ready = 1'b0;
          stall_left--;
        end else bus.out_ready = $urandom_range(99) < 75;
        prev_valid = bus.out_valid;
        prev_ready = bus.out_ready;
        if (bus.out_valid && bus.out_ready) begin
          got++;
          last_pop = got == N_OUT;
        end
      end
    end
    if (!done) check("drain_timeout", 0, 1);
    check("bits_out", got, N_OUT);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.rx_pair = '0;
    bus.out_ready = 1'b0;
    tb_bit = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs();
    rst = 1'b0;
    run_frame(1, 0, 1, 0);
    run_frame(2, 0, 0, 0);
    run_frame(0, 1, 0, 0);
    run_frame(1, 0, 0, 1);
    run_frame(1, 0, 0, 0);
    for (int f = 0; f < 4; f++) run_frame(0, f[0], 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/viterbi_frame_ctrl.md
Name: viterbi_frame_ctrl

Overview:
Frame sequencer for the K=3, rate-1/2 Viterbi decoder datapath. It accepts received symbol pairs over a valid/ready handshake and forwards them to the branch-metric/ACS stage, generating survivor-memory write addresses. At frame end it runs traceback by issuing descending survivor-memory reads and collects the returned decoded bits. It then streams the decoded bits out in original order.

Parameters:
FRAME_LEN, 256, symbol pairs per frame; must be a power of two, at least 8
AW, $clog2(FRAME_LEN), survivor-memory address width

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  rx_pair valid
in_ready  out  1  controller can accept rx_pair
rx_pair  in  2  received symbol pair
bmc_rx_pair  out  2  registered symbol to the branch-metric units
acs_en  out  1  ACS/path-metric update enable
acs_init  out  1  first symbol of frame; ACS loads initial metrics
surv_wr_en  out  1  survivor-memory write strobe
surv_wr_addr  out  AW  survivor-memory write address
tb_start  out  1  one-cycle pulse; datapath latches traceback start state
tb_en  out  1  survivor-memory read enable for traceback
tb_addr  out  AW  traceback read address
tb_bit  in  1  decoded bit, valid 1 cycle after tb_en
out_valid  out  1  decoded bit valid
out_ready  in  1  downstream accepts out_bit
out_bit  out  1  decoded bit, frame order
frame_done  out  1  one-cycle pulse after the last out_bit transfer

Interface: one clock; reset is synchronous and active-high (clk, rst).

Behaviour:
- All outputs are registered. On rst, the FSM goes to IDLE and every output is 0 except in_ready, which is 1 from the first cycle after reset. The symbol counter, traceback counter, drain counter and decoded-bit register clear. A partial frame is discarded; a reset mid-traceback or mid-drain aborts it.
- States: IDLE -> ACC -> TB_START -> TB -> TB_FLUSH -> DRAIN -> IDLE.
- IDLE/ACC: in_ready=1.
  - A transfer (in_valid & in_ready) at cycle t asserts acs_en, surv_wr_en, surv_wr_addr=sym_cnt and bmc_rx_pair=rx_pair at t+1.
  - acs_init=1 only with sym_cnt=0.
  - The first transfer moves IDLE->ACC.
  - Bubbles (in_valid=0) produce acs_en=0 and do not advance the count.
- The transfer with sym_cnt=FRAME_LEN-1 moves the FSM to TB_START. in_ready is 0 from the next cycle. sym_cnt wraps to 0.
- TB_START: one cycle. tb_start=1 arrives one cycle after the final acs_en, so the ACS metrics are settled.
- TB: tb_en=1 for exactly FRAME_LEN consecutive cycles, with tb_addr = FRAME_LEN-1 down to 0.
- tb_bit is sampled the cycle after each read. The bit for address a is stored at decoded-register index a.
- TB_FLUSH: one cycle to capture the tb_bit for address 0.
- DRAIN:
  - out_valid=1 with out_bit = decoded[idx], idx ascending from 0.
  - idx advances only when out_valid & out_ready.
  - When out_ready=0, out_valid and out_bit hold stable.
- The final transfer asserts frame_done at the next cycle and returns the FSM to IDLE, where in_ready=1. Symbols are not accepted during TB_START, TB, TB_FLUSH or DRAIN.
- Simultaneous events: the cycle of the last out transfer does not accept input, because in_ready is still 0.

Optional Feature:
VITERBI_TAIL_FLUSH_EN
- Defined: the frame's last 2 symbols are encoder tail (zero-flush). tb_start is accompanied by a forced start state of 00, output as tb_force_zero=1 for the tb_start cycle (an extra 1-bit output port present only under the macro). DRAIN emits only FRAME_LEN-2 bits; frame_done follows bit FRAME_LEN-3.
- Undefined: tb_force_zero is absent, the datapath starts from the best-metric state, and all FRAME_LEN bits are emitted.

Decomposition:
- Package viterbi_pkg: state enum (IDLE, ACC, TB_START, TB, TB_FLUSH, DRAIN), constants K=3, TAIL_LEN=2, and the symbol-pair typedef (logic[1:0]).
- One sub-module, viterbi_out_buf: FRAME_LEN-bit indexed write / ascending read with valid/ready drain. The FSM and counters stay in the top module.

Test Plan:
- FRAME_LEN=8, 8 back-to-back symbols -> acs_en 8 cycles; acs_init only with surv_wr_addr=0; addresses 0..7; in_ready=0 from the cycle after the 8th transfer; tb_start 1 cycle later.
- Traceback: tb_addr 7,6,...,0 on consecutive cycles; tb_bit driven 1,0,1,1,0,0,1,0 -> out_bit sequence 0,1,0,0,1,1,0,1; frame_done after the 8th bit.
- in_valid toggling 1,0,1,0 -> acs_en only on transfers; surv_wr_addr increments by 1 per transfer with no skips.
- out_ready held 0 for 5 cycles mid-drain -> out_valid=1 and out_bit stable; no bit lost or duplicated.
- rst asserted during TB at tb_addr=4 -> next cycle all outputs 0 except in_ready=1; the next frame starts with acs_init and addr 0.
- With VITERBI_TAIL_FLUSH_EN, FRAME_LEN=8 -> tb_force_zero pulses with tb_start; 6 bits emitted; frame_done after 6th.
